timer_scroll_master: RTL

- Avalon-MM master that drives the 16-bit-data interval-timer slave used for horizontal scrolling.
- After enable it programs the timer period and starts the timer in continuous mode with interrupts on.
- On each timer IRQ it reads and acknowledges the timer status, then advances a wrapping scroll_x position.
- Sits between the timer slave and the video scroll logic; replaces the software ISR for scrolling.

---
 rtl/timer_scroll_master_if.sv | 29 ++
 rtl/timer_scroll_master.sv | 137 +++++++++++++
 2 files changed

// File: rtl/timer_scroll_master_if.sv
// Avalon-MM bus bundle between timer_scroll_master and the interval-timer slave.
//   avm_address    : timer register index (0 status, 1 control, 2 period_l, 3 period_h)
//   avm_chipselect : one-cycle access strobe
//   avm_write_n    : active-low write qualifier
//   avm_writedata  : 16-bit write data
//   avm_readdata   : 16-bit read data, registered in the slave (read latency 1)
interface timer_scroll_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/timer_scroll_master.sv
// Hardware replacement for the scrolling ISR. Programs the interval timer
// (period, continuous mode, interrupts on), then on every timer IRQ reads and
// acknowledges the status register and advances a wrapping scroll_x.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   enable   : level; high runs scrolling, low stops the timer
//   dir      : 0 increments scroll_x, 1 decrements (sampled in UPDATE)
//   irq      : timer interrupt (level)
//   avm      : Avalon-MM master port toward the timer slave
//   scroll_x : current scroll position, wraps at SCROLL_MAX
//   tick     : one-cycle pulse while scroll_x is being updated
//   running  : high while the timer is programmed and started
module timer_scroll_master #(
  parameter logic [31:0] PERIOD     = 32'd49999,
  parameter int unsigned SCROLL_MAX = 639,
  parameter int unsigned STEP       = 1,
  parameter int unsigned XW         = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          dir,
  input  logic                          irq,
  timer_scroll_master_if.master         avm,
  output logic [XW-1:0]                 scroll_x,
  output logic                          tick,
  output logic                          running
);

  localparam logic [XW:0]  STEP_E = (XW+1)'(STEP);
  localparam logic [XW:0]  MAX_E  = (XW+1)'(SCROLL_MAX);
  localparam logic [XW:0]  WRAP_E = (XW+1)'(SCROLL_MAX + 1);
  localparam logic [15:0]  PER_L  = PERIOD[15:0];
  localparam logic [15:0]  PER_H  = PERIOD[31:16];

  typedef enum logic [3:0] {
    IDLE, W_PERL, W_PERH, W_CTRL, WAIT_IRQ,
    RD_STAT, RD_CAP, W_STAT, UPDATE, W_STOP
  } state_t;

  state_t state, state_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Bus outputs are decoded straight from the state so each access occupies
  // exactly the cycle spent in its state; IDLE decodes to the reset values.
  always_comb begin
    state_n            = state;
    avm.avm_chipselect = 1'b0;
    avm.avm_write_n    = 1'b1;
    avm.avm_address    = '0;
    avm.avm_writedata  = '0;
    tick               = 1'b0;
    case (state)
      IDLE: if (enable) state_n = W_PERL;
      W_PERL: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = 3'd2;
        avm.avm_writedata  = PER_L;
        state_n            = W_PERH;
      end
      W_PERH: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = 3'd3;
        avm.avm_writedata  = PER_H;
        state_n            = W_CTRL;
      end
      W_CTRL: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = 3'd1;
        avm.avm_writedata  = 16'h0007;
        state_n            = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        if (!enable)  state_n = W_STOP;
        else if (irq) state_n = RD_STAT;
      end
      RD_STAT: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_address    = 3'd0;
        state_n            = RD_CAP;
      end
      // Read data arrives one cycle after the read; a clear TO bit means the
      // IRQ was spurious and no scroll update happens.
      RD_CAP: state_n = avm.avm_readdata[0] ? W_STAT : WAIT_IRQ;
      W_STAT: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = 3'd0;
        avm.avm_writedata  = 16'h0000;
        state_n            = UPDATE;
      end
      // One spare cycle after the status clear so the stale irq level is
      // never re-sampled in WAIT_IRQ.
      UPDATE: begin
        tick    = 1'b1;
        state_n = WAIT_IRQ;
      end
      W_STOP: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_address    = 3'd1;
        avm.avm_writedata  = 16'h0008;
        state_n            = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Wrapping step computed one bit wider than scroll_x so the compare and the
  // wrap correction never overflow.
  logic [XW:0] x_ext, x_sum, x_next;
  always_comb begin
    x_ext = {1'b0, scroll_x};
    x_sum = x_ext + STEP_E;
    if (!dir) x_next = (x_sum > MAX_E) ? (x_sum - WRAP_E) : x_sum;
    else      x_next = (x_ext < STEP_E) ? (x_ext + WRAP_E - STEP_E) : (x_ext - STEP_E);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_x <= '0;
      running  <= 1'b0;
    end else begin
      if (state == UPDATE) scroll_x <= x_next[XW-1:0];
      if (state == W_CTRL)      running <= 1'b1;
      else if (state == W_STOP) running <= 1'b0;
    end
  end

endmodule
